// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, preloadable instruction memory and IF/ID pipeline latch.
// Redirect takes priority over stall, and stall takes priority over a normal PC+4 advance.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   input  logic        imem_we,
   input  logic [31:0] imem_waddr,
   input  logic [31:0] imem_wdata,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_npc,
   output logic        if_id_valid
);

   localparam int unsigned AW      = $clog2(IMEM_DEPTH);
   localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

   logic [31:0]   mem [IMEM_DEPTH] = '{default: '0};
   logic [31:0]   fetched;
   logic [31:0]   pc_plus4;
   logic [AW-1:0] ridx;
   logic [AW-1:0] widx;
   logic          rd_in_range;
   logic          wr_in_range;
   logic [3:0]    unused_bits;

   // Byte-offset bits are architecturally ignored on both target and preload address.
   assign unused_bits = {branch_target[1:0], imem_waddr[1:0]};

   always_comb begin
      ridx        = pc_out[AW+1:2];
      widx        = imem_waddr[AW+1:2];
      rd_in_range = (pc_out[31:AW+2] == '0);
      wr_in_range = (imem_waddr[31:AW+2] == '0);
      fetched     = rd_in_range ? mem[ridx] : '0;
      pc_plus4    = pc_out + 32'd4;
   end

   // Memory is deliberately outside the reset domain so contents survive rst.
   always_ff @(posedge clk) begin
      if (imem_we && wr_in_range)
         mem[widx] <= imem_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out      <= PC_INIT;
         if_id_instr <= '0;
         if_id_npc   <= '0;
         if_id_valid <= 1'b0;
      end else if (pc_src) begin
         pc_out      <= {branch_target[31:2], 2'b00};
         if_id_instr <= '0;
         if_id_npc   <= '0;
         if_id_valid <= 1'b0;
      end else if (!stall) begin
         pc_out      <= pc_plus4;
         if_id_instr <= fetched;
         if_id_npc   <= pc_plus4;
         if_id_valid <= 1'b1;
      end
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter IMEM_DEPTH, default 128: instruction memory depth in 32-bit words, power of two, 2..1024.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-006 pc_src  input  1  branch/jump taken; redirect fetch.
REQ-007 branch_target  input  32  redirect address, used when pc_src=1.
REQ-008 imem_we  input  1  instruction-memory preload write enable.
REQ-009 imem_waddr  input  32  preload byte address; word index = imem_waddr[31:2].
REQ-010 imem_wdata  input  32  preload data word.
REQ-011 pc_out  output  32  current fetch PC.
REQ-012 if_id_instr  output  32  IF/ID latched instruction; feeds decode (rs=[25:21], rt=[20:16], rd=[15:11]).
REQ-013 if_id_npc  output  32  IF/ID latched PC+4.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-015 Instruction memory: IMEM_DEPTH x 32 array, all words 0 (NOP) at time zero; async combinational read at index pc_out[31:2].
REQ-016 Fetched word = 32'h0 when pc_out[31:2] >= IMEM_DEPTH (out of range).
REQ-017 Preload write: on clk edge with imem_we=1 and imem_waddr[31:2] < IMEM_DEPTH, word written; out-of-range writes ignored; imem_waddr[1:0] ignored.
REQ-018 Same-edge write and fetch of same word: IF/ID captures old contents (read-before-write).
REQ-019 Per-edge priority (rst aside): pc_src > stall > normal advance.
REQ-020 Redirect (pc_src=1): PC <= {branch_target[31:2],2'b00}; IF/ID <= bubble (instr 0, npc 0, valid 0); applies even if stall=1.
REQ-021 Stall (pc_src=0, stall=1): PC and all IF/ID outputs hold their values.
REQ-022 Advance (pc_src=0, stall=0): PC <= PC+4; if_id_instr <= fetched word; if_id_npc <= PC+4; if_id_valid <= 1.
REQ-023 PC+4 arithmetic modulo 2^32: PC=32'hFFFFFFFC advances to 32'h00000000.
REQ-024 PC[1:0] always 2'b00; RESET_PC[1:0] forced to 0.
REQ-025 Latency: instruction at PC appears on if_id_instr one edge after PC is presented, no stall.
REQ-026 Throughput: one instruction per cycle when stall=0 and pc_src=0.
REQ-027 Preload writes proceed independently of stall, pc_src and rst.

Reset
REQ-028 rst=1 forces immediately, independent of clk: pc_out=RESET_PC, if_id_instr=0, if_id_npc=0, if_id_valid=0.
REQ-029 While rst=1, stall/pc_src/branch_target ignored; first advance on first rising edge after rst deasserts.
REQ-030 rst does not clear instruction memory; contents survive mid-operation reset.

Verification
REQ-031 Preload words 0..3 = 8C123456, 8F123456, AD654321, 13012345; release rst; 4 edges -> if_id_instr sequence 8C123456, 8F123456, AD654321, 13012345; if_id_npc 4, 8, C, 10; valid=1.
REQ-032 Running at pc_out=8, stall=1 for 3 edges -> pc_out stays 8, if_id_instr stays 8F123456; release -> next edge AD654321, npc=C.
REQ-033 pc_out=C, pc_src=1, branch_target=32'h00000006 (stall=1 too) -> next edge pc_out=4, if_id_valid=0, instr=0; following edge instr=8F123456, npc=8.
REQ-034 Redirect to 32'hFFFFFFFC -> instr=0 (out of range), then pc_out wraps to 0; following edge instr=8C123456.
REQ-035 Assert rst asynchronously mid-run between edges -> outputs reset immediately without edge; after release, fetch restarts at 0 returning 8C123456 (memory retained).
REQ-036 imem_we to word 2 (data 60000066) on the same edge pc_out=8 is fetched -> if_id_instr=AD654321; refetch of 8 after redirect returns 60000066.
